axis_decimator: RTL and testbench
=================================

Name: axis_decimator

Overview:
- AXI-Stream consumer placed directly downstream of the 15-tap FIR low-pass.
- Receives filtered samples and keeps one of every D samples, where D is the runtime decimation factor. Frame boundaries (tlast) are preserved.
- Forwards kept samples on an AXI-Stream master port through a 2-entry skid buffer, so tready is fully registered and backpressure is exact, with no dropped or duplicated beats.
- Reports frame and sample statistics for the PS.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input sample width (packed I/Q: real [31:16], imag [15:0])
- C_M00_AXIS_TDATA_WIDTH, 32, output sample width; must equal C_S00_AXIS_TDATA_WIDTH
- DECIM_WIDTH, 8, width of decim_factor and of the internal phase counter

Ports:
- s00_axis_aclk  in  1  single clock for the whole block
- s00_axis_aresetn  in  1  reset; one clock; reset is asynchronous and active-low
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  input sample
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  input byte strobes
- s00_axis_tvalid  in  1  input valid
- s00_axis_tlast  in  1  last input beat of frame
- s00_axis_tready  out  1  input ready
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  output sample
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  output strobes, copied from the kept input beat
- m00_axis_tvalid  out  1  output valid
- m00_axis_tlast  out  1  last output beat of frame
- m00_axis_tready  in  1  downstream ready
- decim_factor  in  DECIM_WIDTH  D; sampled only at frame start; 0 is treated as 1
- frames_out  out  16  count of output beats accepted with tlast; wraps at 65535->0
- samples_in  out  32  count of accepted input beats; wraps

Behaviour:
- Reset (async, aresetn=0):
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0.
  - s00_axis_tready=0 while reset is asserted.
  - frames_out=0, samples_in=0, phase=0, skid buffer empty, state=IDLE.
  - On the first clock edge after deassertion, s00_axis_tready=1.
- Input acceptance: a beat is accepted when s00_axis_tvalid & s00_axis_tready. samples_in increments on every accepted beat.
- States:
  - IDLE: no frame in progress. On an accepted beat:
    - latch D_eff = max(decim_factor, 1).
    - The beat is phase 0 and is kept.
    - If tlast=1, stay IDLE; otherwise go to RUN with phase=1 (or phase=0 if D_eff=1).
  - RUN: each accepted beat is kept if phase==0 or tlast==1; otherwise it is dropped.
    - phase increments and wraps from D_eff-1 to 0.
    - An accepted beat with tlast=1 returns the block to IDLE with phase=0. D_eff is re-latched on the next frame.
- Kept beat: {tdata, tstrb, tlast} is written into the skid buffer unchanged. A tlast beat is always forwarded, even off-phase, so every input frame produces exactly one output tlast.
- Skid buffer: 2 entries, FIFO order, registered outputs.
  - s00_axis_tready = (occupancy < 2), registered.
  - Latency: a kept beat appears on m00 one cycle after it is accepted when the buffer is empty.
  - Output pop and input push in the same cycle: occupancy is unchanged and order is preserved.
  - Full (occupancy 2): tready=0 and no beat is lost. Dropped beats are still throttled by tready; they are never accepted while the buffer is full.
- AXI rules on m00: while tvalid=1 and tready=0, tdata, tstrb and tlast are held stable and tvalid is not deasserted.
- Counters: frames_out increments when m00_axis_tvalid & m00_axis_tready & m00_axis_tlast.
- decim_factor changes mid-frame have no effect until the next frame.
- Reset mid-frame: everything clears immediately; the partial frame is discarded with no tlast emitted.

Test Plan:
- D=4, 16-beat frame, data 0..15, tlast on beat 15, m_tready=1 -> output 0,4,8,12,15; tlast only on 15; frames_out=1; samples_in=16.
- D=1 (and D=0), 5-beat frame 10..14 -> all 5 beats output unchanged with 1-cycle latency; tlast on 14.
- D=3, continuous input, m_tready toggling 1,0,0,1 -> output sequence 0,3,6,... with no gaps or duplicates; s_tready drops to 0 when occupancy reaches 2; m00 data stable while stalled.
- decim_factor changed 2->5 at beat 3 of a 10-beat frame -> frame 1 output 0,2,4,6,8,9; next frame uses D=5 -> 0,5,9.
- Single-beat frame (tlast on the first beat), D=8 -> one output beat with tlast; state stays IDLE; frames_out increments.
- aresetn pulsed low mid-frame with 2 beats buffered -> m00_axis_tvalid=0 immediately; after release the next frame restarts at phase 0; counters read 0.

Source files
------------

// File: rtl/axis_decimator.sv
// AXI-Stream decimator: keeps one of every D input beats (tlast beats are always kept)
// and forwards them through a 2-entry skid buffer with a registered s00_axis_tready.
module axis_decimator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DECIM_WIDTH            = 8
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready,
    input  logic [DECIM_WIDTH-1:0]                decim_factor,
    output logic [15:0]                           frames_out,
    output logic [31:0]                           samples_in
);
    localparam int MSW = C_M00_AXIS_TDATA_WIDTH / 8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state, state_nxt;
    logic [DECIM_WIDTH-1:0]      phase, phase_nxt, d_eff, d_eff_nxt, d_in;
    logic                        accept, keep, push, pop, full_nxt;
    logic                        s_rdy, hd_vld, sk_vld;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] hd_data, sk_data;
    logic [MSW-1:0]              hd_strb, sk_strb;
    logic                        hd_last, sk_last;
    logic [15:0]                 frames_cnt;
    logic [31:0]                 samples_cnt;

    assign accept = s00_axis_tvalid & s_rdy;
    assign d_in   = (decim_factor == '0) ? DECIM_WIDTH'(1) : decim_factor;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state <= IDLE;
            phase <= '0;
            d_eff <= DECIM_WIDTH'(1);
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            d_eff <= d_eff_nxt;
        end
    end

    // D is only latched on the first beat of a frame; tlast is kept even off-phase
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        d_eff_nxt = d_eff;
        keep      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    keep      = 1'b1;
                    d_eff_nxt = d_in;
                    phase_nxt = '0;
                    if (!s00_axis_tlast) begin
                        state_nxt = RUN;
                        phase_nxt = (d_in == DECIM_WIDTH'(1)) ? '0 : DECIM_WIDTH'(1);
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    keep = (phase == '0) || s00_axis_tlast;
                    if (s00_axis_tlast) begin
                        state_nxt = IDLE;
                        phase_nxt = '0;
                    end else if (phase == d_eff - DECIM_WIDTH'(1)) begin
                        phase_nxt = '0;
                    end else begin
                        phase_nxt = phase + DECIM_WIDTH'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push = accept & keep;
    assign pop  = hd_vld & m00_axis_tready;
    // tready is registered, so it must already reflect the occupancy after this edge
    assign full_nxt = (hd_vld & sk_vld & ~pop) | (hd_vld & ~sk_vld & push & ~pop);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            s_rdy   <= 1'b0;
            hd_vld  <= 1'b0;
            sk_vld  <= 1'b0;
            hd_data <= '0;
            hd_strb <= '0;
            hd_last <= 1'b0;
            sk_data <= '0;
            sk_strb <= '0;
            sk_last <= 1'b0;
        end else begin
            s_rdy <= ~full_nxt;
            if (pop) begin
                if (sk_vld) begin
                    hd_data <= sk_data;
                    hd_strb <= sk_strb;
                    hd_last <= sk_last;
                    sk_vld  <= 1'b0;
                end else if (push) begin
                    hd_data <= s00_axis_tdata;
                    hd_strb <= s00_axis_tstrb;
                    hd_last <= s00_axis_tlast;
                end else begin
                    hd_vld <= 1'b0;
                end
            end else if (push) begin
                if (!hd_vld) begin
                    hd_data <= s00_axis_tdata;
                    hd_strb <= s00_axis_tstrb;
                    hd_last <= s00_axis_tlast;
                    hd_vld  <= 1'b1;
                end else begin
                    sk_data <= s00_axis_tdata;
                    sk_strb <= s00_axis_tstrb;
                    sk_last <= s00_axis_tlast;
                    sk_vld  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            frames_cnt  <= '0;
            samples_cnt <= '0;
        end else begin
            if (accept)
                samples_cnt <= samples_cnt + 32'd1;
            if (pop && hd_last)
                frames_cnt <= frames_cnt + 16'd1;
        end
    end

    assign s00_axis_tready = s_rdy;
    assign m00_axis_tvalid = hd_vld;
    assign m00_axis_tdata  = hd_data;
    assign m00_axis_tstrb  = hd_strb;
    assign m00_axis_tlast  = hd_last;
    assign frames_out      = frames_cnt;
    assign samples_in      = samples_cnt;

endmodule

// File: tb/tb_axis_decimator.sv
// Randomized bench for axis_decimator: stimulus queues feed the DUT and a frame-level
// reference model (keep index%D==0 or tlast) predicts the output stream and counters.
module tb_axis_decimator;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int DCW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   s_tdata = '0;
    logic [SW-1:0]   s_tstrb = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tlast = 1'b0;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready = 1'b1;
    logic [DCW-1:0]  decim = 8'd1;
    logic [15:0]     frames_out;
    logic [31:0]     samples_in;

    axis_decimator #(
        .C_S00_AXIS_TDATA_WIDTH(DW),
        .C_M00_AXIS_TDATA_WIDTH(DW),
        .DECIM_WIDTH(DCW)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready),
        .decim_factor(decim),
        .frames_out(frames_out),
        .samples_in(samples_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int exp_frames = 0;
    int exp_samples = 0;

    logic [DW-1:0] q_data[$];
    logic [SW-1:0] q_strb[$];
    bit            q_last[$];
    int            q_df[$];
    logic [DW-1:0] e_data[$];
    logic [SW-1:0] e_strb[$];
    bit            e_last[$];
    logic [DW-1:0] g_data[$];
    logic [SW-1:0] g_strb[$];
    bit            g_last[$];
    bit            saw_full;

    task automatic push_beat(input logic [DW-1:0] d, input bit last, input int df);
        q_data.push_back(d);
        q_strb.push_back(SW'($urandom_range(0, (1 << SW) - 1)));
        q_last.push_back(last);
        q_df.push_back(df);
    endtask

    task automatic add_seq_frame(input int len, input int base, input int df0,
                                 input int chg_at, input int df1);
        for (int i = 0; i < len; i++)
            push_beat(DW'(base + i), (i == len - 1), (chg_at >= 0 && i >= chg_at) ? df1 : df0);
    endtask

    // Reference: D taken from the first beat of each frame; keep beat k if k%D==0 or last
    task automatic build_expected();
        int d = 1;
        int idx = 0;
        e_data.delete(); e_strb.delete(); e_last.delete();
        for (int i = 0; i < q_data.size(); i++) begin
            if (idx == 0) d = (q_df[i] == 0) ? 1 : q_df[i];
            if ((idx % d) == 0 || q_last[i]) begin
                e_data.push_back(q_data[i]);
                e_strb.push_back(q_strb[i]);
                e_last.push_back(q_last[i]);
            end
            exp_samples++;
            if (q_last[i]) begin
                exp_frames++;
                idx = 0;
            end else begin
                idx++;
            end
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (frames_out !== 16'(exp_frames) || samples_in !== 32'(exp_samples)) begin
            fails++;
            $display("FAIL %s counters: got frames_out=%0d samples_in=%0d, expected %0d %0d",
                     name, frames_out, samples_in, exp_frames, exp_samples);
        end
    endtask

    // Caller must be at posedge+1. rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
    task automatic run_traffic(input string name, input int rmode, input bit gaps);
        int n_in, n_exp, i, c, cyc, pc;
        bit acc, drv_to, stall;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        bit pl;
        n_in = q_data.size();
        build_expected();
        n_exp = e_data.size();
        g_data.delete(); g_strb.delete(); g_last.delete();
        saw_full = 0;
        drv_to = 0;
        fork
            begin
                for (i = 0; i < n_in && !drv_to; i++) begin
                    if (gaps) begin
                        repeat ($urandom_range(0, 2)) begin
                            s_tvalid = 1'b0;
                            @(posedge clk); #1;
                        end
                    end
                    s_tvalid = 1'b1;
                    s_tdata  = q_data[i];
                    s_tstrb  = q_strb[i];
                    s_tlast  = q_last[i];
                    decim    = DCW'(q_df[i]);
                    c = 0;
                    do begin
                        @(negedge clk);
                        acc = (s_tready === 1'b1);
                        @(posedge clk); #1;
                        c++;
                    end while (!acc && c < 2000);
                    if (!acc) drv_to = 1;
                end
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            begin
                cyc = 0; pc = 0; stall = 0; pd = '0; ps = '0; pl = 0;
                while (g_data.size() < n_exp && cyc < 5000) begin
                    @(posedge clk); #1;
                    case (rmode)
                        0: m_tready = 1'b1;
                        1: m_tready = (pc % 4 == 0) || (pc % 4 == 3);
                        default: m_tready = 1'($urandom_range(0, 1));
                    endcase
                    pc++;
                    @(negedge clk);
                    cyc++;
                    if (stall) begin
                        checks++;
                        if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tstrb !== ps || m_tlast !== pl) begin
                            fails++;
                            $display("FAIL %s hold: got valid=%b data=%h strb=%h last=%b, expected 1 %h %h %b",
                                     name, m_tvalid, m_tdata, m_tstrb, m_tlast, pd, ps, pl);
                        end
                    end
                    if (s_tready === 1'b0) saw_full = 1;
                    if (m_tvalid === 1'b1 && m_tready) begin
                        g_data.push_back(m_tdata);
                        g_strb.push_back(m_tstrb);
                        g_last.push_back(m_tlast);
                    end
                    stall = (m_tvalid === 1'b1) && !m_tready;
                    pd = m_tdata; ps = m_tstrb; pl = m_tlast;
                end
            end
        join
        @(posedge clk); #1;
        m_tready = 1'b1;
        // let any beat still buffered drain so counters settle
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (drv_to || g_data.size() != n_exp || m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL %s count: got %0d beats (drv_timeout=%b, trailing valid=%b), expected %0d",
                     name, g_data.size(), drv_to, m_tvalid, n_exp);
        end
        for (int k = 0; k < n_exp && k < g_data.size(); k++) begin
            checks++;
            if (g_data[k] !== e_data[k] || g_strb[k] !== e_strb[k] || g_last[k] !== e_last[k]) begin
                fails++;
                $display("FAIL %s beat %0d: got data=%h strb=%h last=%b, expected data=%h strb=%h last=%b",
                         name, k, g_data[k], g_strb[k], g_last[k], e_data[k], e_strb[k], e_last[k]);
            end
        end
        check_counters(name);
        q_data.delete(); q_strb.delete(); q_last.delete(); q_df.delete();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 ||
            s_tready !== 1'b0 || frames_out !== '0 || samples_in !== '0) begin
            fails++;
            $display("FAIL reset_state: got valid=%b last=%b data=%h strb=%h s_rdy=%b frames=%0d samples=%0d, expected all 0",
                     m_tvalid, m_tlast, m_tdata, m_tstrb, s_tready, frames_out, samples_in);
        end
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_tready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, expected 1", s_tready);
        end
    endtask

    task automatic test_decim4();
        add_seq_frame(16, 0, 4, -1, 0);
        run_traffic("decim4", 0, 0);
    endtask

    task automatic test_d1_d0();
        add_seq_frame(5, 10, 1, -1, 0);
        add_seq_frame(5, 10, 0, -1, 0);
        run_traffic("d1_d0", 0, 0);
    endtask

    task automatic test_backpressure();
        add_seq_frame(30, 0, 3, -1, 0);
        add_seq_frame(12, 200, 1, -1, 0);
        run_traffic("backpressure", 1, 0);
        checks++;
        if (!saw_full) begin
            fails++;
            $display("FAIL backpressure_ready_drop: got s_tready never 0, expected a 0");
        end
    endtask

    task automatic test_decim_change();
        add_seq_frame(10, 0, 2, 3, 5);
        add_seq_frame(10, 0, 5, -1, 0);
        run_traffic("decim_change", 0, 1);
    endtask

    task automatic test_single();
        logic [DW-1:0] v;
        v = DW'($urandom);
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = v; s_tstrb = 4'hA; s_tlast = 1'b1; decim = 8'd8;
        @(negedge clk);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
        exp_samples++;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== v || m_tstrb !== 4'hA || m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: got valid=%b data=%h strb=%h last=%b, expected 1 %h a 1",
                     m_tvalid, m_tdata, m_tstrb, m_tlast, v);
        end
        @(posedge clk); #1;
        exp_frames++;
        check_counters("single");
        add_seq_frame(4, 50, 2, -1, 0);
        run_traffic("after_single", 0, 0);
    endtask

    task automatic test_random();
        int len, df;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 20);
            df = $urandom_range(0, 6);
            for (int i = 0; i < len; i++)
                push_beat(DW'($urandom), (i == len - 1), (i == 0) ? df : $urandom_range(0, 6));
        end
        run_traffic("random", 2, 1);
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0;
        decim = 8'd1;
        s_tvalid = 1'b1; s_tdata = 32'hAAAA_0001; s_tstrb = 4'hF; s_tlast = 1'b0;
        @(posedge clk); #1;
        s_tdata = 32'hAAAA_0002;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'hAAAA_0001) begin
            fails++;
            $display("FAIL reset_mid_full: got s_rdy=%b valid=%b data=%h, expected 0 1 aaaa0001",
                     s_tready, m_tvalid, m_tdata);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || frames_out !== '0 || samples_in !== '0) begin
            fails++;
            $display("FAIL reset_mid_clear: got valid=%b s_rdy=%b frames=%0d samples=%0d, expected 0 0 0 0",
                     m_tvalid, s_tready, frames_out, samples_in);
        end
        exp_frames = 0;
        exp_samples = 0;
        #1 rst_n = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        add_seq_frame(5, 100, 2, -1, 0);
        run_traffic("after_reset_mid", 0, 0);
    endtask

    initial begin
        test_reset();
        test_decim4();
        test_d1_d0();
        test_backpressure();
        test_decim_change();
        test_single();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
